// File: rtl/spi_slave_fifo.sv
// SPI slave, system-clock domain, oversampled inputs, TX/RX FIFOs.
// Optional: SPI_LSB_FIRST_EN selects LSB-first shifting (default MSB first).
module spi_slave_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  ss,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_wr,
  output logic                  tx_full,
  output logic                  tx_empty,
  output logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_rd,
  output logic                  rx_data_available,
  output logic                  rx_overrun,
  output logic                  tx_underrun,
  input  logic                  status_clr,
  output logic                  busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic IDLE_LVL = (CPOL != 0);
  localparam logic SMP_RISE = (CPOL == CPHA);
  localparam logic PHA0 = (CPHA == 0);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e state_q, state_d;

  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic ss_s1_q, ss_s2_q;
  logic mosi_s1_q, mosi_s2_q;

  logic [DATA_WIDTH-1:0] shift_q, rx_shift_q;
  logic [BW-1:0]         bit_cnt_q;
  logic                  push_pend_q, load_pend_q;

  logic [DATA_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [CW-1:0] tx_cnt_q, rx_cnt_q;
  logic          rx_ovr_q, tx_und_q;

  logic sclk_rise, sclk_fall, smp_edge, shf_edge;
  logic enter, act_ev, do_smp, do_shf, word_done;
  logic load, shift;
  logic tx_acc, tx_pop, rx_acc, rx_pop;
  logic [DATA_WIDTH-1:0] shift_nx, rx_shift_nx;

  // Two-flop synchronizers plus one history flop for sclk edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1_q <= IDLE_LVL;
      sclk_s2_q <= IDLE_LVL;
      sclk_s3_q <= IDLE_LVL;
      ss_s1_q   <= 1'b1;
      ss_s2_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sclk_s1_q <= sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      ss_s1_q   <= ss;
      ss_s2_q   <= ss_s1_q;
      mosi_s1_q <= mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
  assign smp_edge  = SMP_RISE ? sclk_rise : sclk_fall;
  assign shf_edge  = SMP_RISE ? sclk_fall : sclk_rise;

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Frame next-state: follows synchronized slave select
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (!ss_s2_q) state_d = ACTIVE;
      ACTIVE: if (ss_s2_q)  state_d = IDLE;
    endcase
  end

  assign enter     = (state_q == IDLE) & ~ss_s2_q;
  assign act_ev    = (state_q == ACTIVE) & ~ss_s2_q;
  assign do_smp    = act_ev & smp_edge;
  assign do_shf    = act_ev & shf_edge;
  assign word_done = do_smp & (bit_cnt_q == BW'(DATA_WIDTH - 1));

  // CPHA=0 must present the MSB before the first sample edge, so it
  // loads early and skips the trailing edge that closes each word.
  assign load  = PHA0 ? (enter | (act_ev & load_pend_q))
                      : (do_shf & (bit_cnt_q == '0));
  assign shift = do_shf & (bit_cnt_q != '0) & ~load;

`ifdef SPI_LSB_FIRST_EN
  assign shift_nx    = {1'b0, shift_q[DATA_WIDTH-1:1]};
  assign rx_shift_nx = {mosi_s2_q, rx_shift_q[DATA_WIDTH-1:1]};
  assign miso        = shift_q[0];
`else
  assign shift_nx    = {shift_q[DATA_WIDTH-2:0], 1'b0};
  assign rx_shift_nx = {rx_shift_q[DATA_WIDTH-2:0], mosi_s2_q};
  assign miso        = shift_q[DATA_WIDTH-1];
`endif

  assign miso_oe = (state_q == ACTIVE);
  assign busy    = (state_q == ACTIVE);

  // Shift registers, bit counter and deferred push/load strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      rx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      push_pend_q <= 1'b0;
      load_pend_q <= 1'b0;
    end else begin
      push_pend_q <= word_done;
      load_pend_q <= PHA0 & word_done;
      if (load)       shift_q <= tx_empty ? '0 : tx_mem_q[tx_rp_q];
      else if (shift) shift_q <= shift_nx;
      if (do_smp) rx_shift_q <= rx_shift_nx;
      if (!act_ev)     bit_cnt_q <= '0;
      else if (do_smp) bit_cnt_q <= word_done ? '0 : bit_cnt_q + BW'(1);
    end
  end

  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_acc   = tx_wr & ~tx_full;
  assign tx_pop   = load & ~tx_empty;

  // TX FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) tx_mem_q[i] <= '0;
    end else begin
      if (tx_acc) begin
        tx_mem_q[tx_wp_q] <= tx_data;
        tx_wp_q <= tx_wp_q + AW'(1);
      end
      if (tx_pop) tx_rp_q <= tx_rp_q + AW'(1);
      if (tx_acc && !tx_pop)      tx_cnt_q <= tx_cnt_q + CW'(1);
      else if (!tx_acc && tx_pop) tx_cnt_q <= tx_cnt_q - CW'(1);
    end
  end

  assign rx_data_available = (rx_cnt_q != '0);
  assign rx_data = rx_mem_q[rx_rp_q];
  assign rx_pop  = rx_rd & rx_data_available;
  assign rx_acc  = push_pend_q & ((rx_cnt_q != CW'(FIFO_DEPTH)) | rx_pop);

  // RX FIFO (first-word-fall-through head)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) rx_mem_q[i] <= '0;
    end else begin
      if (rx_acc) begin
        rx_mem_q[rx_wp_q] <= rx_shift_q;
        rx_wp_q <= rx_wp_q + AW'(1);
      end
      if (rx_pop) rx_rp_q <= rx_rp_q + AW'(1);
      if (rx_acc && !rx_pop)      rx_cnt_q <= rx_cnt_q + CW'(1);
      else if (!rx_acc && rx_pop) rx_cnt_q <= rx_cnt_q - CW'(1);
    end
  end

  // Sticky error flags; a set event beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ovr_q <= 1'b0;
      tx_und_q <= 1'b0;
    end else begin
      if (push_pend_q && !rx_acc) rx_ovr_q <= 1'b1;
      else if (status_clr)        rx_ovr_q <= 1'b0;
      if (load && tx_empty)       tx_und_q <= 1'b1;
      else if (status_clr)        tx_und_q <= 1'b0;
    end
  end

  assign rx_overrun  = rx_ovr_q;
  assign tx_underrun = tx_und_q;

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench: four DUTs (SPI modes 0..3); mode 0 is tracked by a queue model.
// Directed frames with literal checks plus per-cycle idle-state compare.
module tb_spi_slave_fifo;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic       sclk [4];
  logic       ss [4];
  logic       mosi [4];
  logic       miso [4];
  logic       miso_oe [4];
  logic [7:0] tx_data [4];
  logic       tx_wr [4];
  logic       tx_full [4];
  logic       tx_empty [4];
  logic [7:0] rx_data [4];
  logic       rx_rd [4];
  logic       rx_av [4];
  logic       rx_ovr [4];
  logic       tx_und [4];
  logic       status_clr [4];
  logic       busy [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_fifo #(
      .DATA_WIDTH(8), .FIFO_DEPTH(4), .CPOL(g / 2), .CPHA(g % 2)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .sclk(sclk[g]), .ss(ss[g]), .mosi(mosi[g]),
      .miso(miso[g]), .miso_oe(miso_oe[g]),
      .tx_data(tx_data[g]), .tx_wr(tx_wr[g]),
      .tx_full(tx_full[g]), .tx_empty(tx_empty[g]),
      .rx_data(rx_data[g]), .rx_rd(rx_rd[g]),
      .rx_data_available(rx_av[g]),
      .rx_overrun(rx_ovr[g]), .tx_underrun(tx_und[g]),
      .status_clr(status_clr[g]), .busy(busy[g])
    );
  end

  int nchk = 0;
  int nerr = 0;
  bit quiet = 1'b0;

  logic [7:0] mtx [$];
  logic [7:0] mrx [$];
  bit movr = 1'b0;
  bit mund = 1'b0;

  logic [7:0] mw [8];
  logic [7:0] mr [8];
  logic [7:0] v;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Idle-time compare of mode-0 DUT against the queue model
  always @(negedge clk) begin
    if (quiet) begin
      chk("busy", busy[0], 0);
      chk("miso_oe", miso_oe[0], 0);
      chk("tx_empty", tx_empty[0], mtx.size() == 0);
      chk("tx_full", tx_full[0], mtx.size() == 4);
      chk("rx_avail", rx_av[0], mrx.size() != 0);
      if (mrx.size() != 0) chk("rx_data", rx_data[0], mrx[0]);
      chk("rx_overrun", rx_ovr[0], movr);
      chk("tx_underrun", tx_und[0], mund);
    end
  end

  task automatic push_tx(int m, logic [7:0] d);
    tx_data[m] = d;
    tx_wr[m] = 1'b1;
    tick(1);
    tx_wr[m] = 1'b0;
    if (m == 0 && mtx.size() < 4) mtx.push_back(d);
  endtask

  task automatic pop_rx(int m, output logic [7:0] d);
    d = rx_data[m];
    rx_rd[m] = 1'b1;
    tick(1);
    rx_rd[m] = 1'b0;
    if (m == 0 && mrx.size() != 0) void'(mrx.pop_front());
  endtask

  task automatic clr(int m);
    status_clr[m] = 1'b1;
    tick(1);
    status_clr[m] = 1'b0;
    if (m == 0) begin
      movr = 1'b0;
      mund = 1'b0;
    end
  endtask

  // Master: nw full words from mw, then pbits of word nw; reads into mr
  task automatic frame(int m, int nw, int pbits);
    logic cp, ch;
    logic [7:0] acc;
    logic [7:0] er [8];
    int nb, bi;
    cp = (m >= 2);
    ch = (m % 2) == 1;
    if (m == 0) quiet = 1'b0;
    ss[m] = 1'b0;
    tick(HALF);
    for (int k = 0; k <= nw; k++) begin
      nb = (k < nw) ? 8 : pbits;
      acc = 8'h00;
      for (int b = 0; b < nb; b++) begin
`ifdef SPI_LSB_FIRST_EN
        bi = b;
`else
        bi = 7 - b;
`endif
        if (!ch) begin
          mosi[m] = mw[k][bi];
          tick(HALF);
          sclk[m] = ~cp;
          acc[bi] = miso[m];
          tick(HALF);
          sclk[m] = cp;
        end else begin
          sclk[m] = ~cp;
          mosi[m] = mw[k][bi];
          tick(HALF);
          sclk[m] = cp;
          acc[bi] = miso[m];
          tick(HALF);
        end
      end
      if (k < nw) mr[k] = acc;
    end
    tick(HALF);
    ss[m] = 1'b1;
    mosi[m] = 1'b0;
    tick(8);
    if (m == 0) begin
      // Mode 0 loads once on frame entry and once after every word
      for (int l = 0; l <= nw; l++) begin
        if (mtx.size() != 0) er[l] = mtx.pop_front();
        else begin
          er[l] = 8'h00;
          mund = 1'b1;
        end
      end
      for (int k = 0; k < nw; k++) begin
        chk("model_miso", mr[k], er[k]);
        if (mrx.size() < 4) mrx.push_back(mw[k]);
        else movr = 1'b1;
      end
      quiet = 1'b1;
      tick(1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int g = 0; g < 4; g++) begin
      sclk[g] = (g >= 2);
      ss[g] = 1'b1;
      mosi[g] = 1'b0;
      tx_data[g] = 8'h00;
      tx_wr[g] = 1'b0;
      rx_rd[g] = 1'b0;
      status_clr[g] = 1'b0;
    end
    rst_n = 1'b0;
    tick(3);
    chk("rst_miso", miso[0], 0);
    chk("rst_oe", miso_oe[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_tx_empty", tx_empty[0], 1);
    chk("rst_rx_av", rx_av[0], 0);
    chk("rst_rx_data", rx_data[0], 0);
    chk("rst_flags", {rx_ovr[0], tx_und[0]}, 0);
    rst_n = 1'b1;
    tick(2);
    quiet = 1'b1;

    // Basic mode-0 exchange
    push_tx(0, 8'h0D);
    mw[0] = 8'h52;
    frame(0, 1, 0);
    chk("t1_master_rd", mr[0], 8'h0D);
    chk("t1_rx_data", rx_data[0], 8'h52);
    chk("t1_rx_av", rx_av[0], 1);
    pop_rx(0, v);
    clr(0);

    // All four modes, same data
    for (int m = 0; m < 4; m++) begin
      push_tx(m, 8'hA5);
      mw[0] = 8'h3C;
      frame(m, 1, 0);
      chk($sformatf("t2_m%0d_rd", m), mr[0], 8'hA5);
      chk($sformatf("t2_m%0d_rx", m), rx_data[m], 8'h3C);
      chk($sformatf("t2_m%0d_av", m), rx_av[m], 1);
      pop_rx(m, v);
    end
    clr(0);

    // Five words into a depth-4 RX FIFO
    mw[0] = 8'h11; mw[1] = 8'h22; mw[2] = 8'h33;
    mw[3] = 8'h44; mw[4] = 8'h55;
    frame(0, 5, 0);
    chk("t3_ovr", rx_ovr[0], 1);
    pop_rx(0, v); chk("t3_w0", v, 8'h11);
    pop_rx(0, v); chk("t3_w1", v, 8'h22);
    pop_rx(0, v); chk("t3_w2", v, 8'h33);
    pop_rx(0, v); chk("t3_w3", v, 8'h44);
    tick(1);
    chk("t3_empty", rx_av[0], 0);
    clr(0);
    tick(1);
    chk("t3_clr", rx_ovr[0], 0);

    // Underrun, then a later write is sent
    mw[0] = 8'h99;
    frame(0, 1, 0);
    chk("t4_zero", mr[0], 8'h00);
    chk("t4_und", tx_und[0], 1);
    pop_rx(0, v);
    clr(0);
    push_tx(0, 8'h5A);
    mw[0] = 8'h66;
    frame(0, 1, 0);
    chk("t4_next", mr[0], 8'h5A);
    pop_rx(0, v);
    clr(0);

    // Aborted frame after three bits, then realigned word
    push_tx(0, 8'h77);
    mw[0] = 8'hFF;
    frame(0, 0, 3);
    chk("t5_busy", busy[0], 0);
    chk("t5_no_push", rx_av[0], 0);
    push_tx(0, 8'h3E);
    mw[0] = 8'h81;
    frame(0, 1, 0);
    chk("t5_rx", rx_data[0], 8'h81);
    chk("t5_rd", mr[0], 8'h3E);

    // Asynchronous reset mid-frame with data held
    push_tx(0, 8'h12);
    push_tx(0, 8'h34);
    quiet = 1'b0;
    ss[0] = 1'b0;
    tick(HALF);
    mosi[0] = 1'b1;
    tick(HALF);
    sclk[0] = 1'b1;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy[0], 0);
    chk("t6_oe", miso_oe[0], 0);
    chk("t6_miso", miso[0], 0);
    chk("t6_tx_empty", tx_empty[0], 1);
    chk("t6_rx_av", rx_av[0], 0);
    chk("t6_rx_data", rx_data[0], 0);
    chk("t6_flags", {rx_ovr[0], tx_und[0]}, 0);
    mtx.delete();
    mrx.delete();
    movr = 1'b0;
    mund = 1'b0;
    ss[0] = 1'b1;
    sclk[0] = 1'b0;
    mosi[0] = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    quiet = 1'b1;

    push_tx(0, 8'hC3);
    mw[0] = 8'h3C;
    frame(0, 1, 0);
    chk("t6_after_rd", mr[0], 8'hC3);
    chk("t6_after_rx", rx_data[0], 8'h3C);
    tick(4);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
